conv_kxk_mac: RTL and testbench
===============================

# conv_kxk_mac

Parametrised, pipelined K×K convolution MAC for the CNN datapath. It multiplies an unsigned feature-map window by a signed weight window and reduces the products through a registered adder tree. It accumulates results across CIN consecutive input-channel windows and emits one saturated output pixel per CIN accepted windows. It sits between the line-buffer window generator and the output-feature-map writer. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- K, 3, window edge; window holds K*K elements
- DW, 8, unsigned ifm element width
- WW, 8, signed weight element width
- CIN, 1, input channels accumulated per output pixel (≥1)
- ACCW, 32, accumulator width; must be ≥ DW+WW+1+clog2(K*K)+clog2(CIN)
- OW, 18, signed output width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  window/weight pair present
- in_ready  out  1  block can accept this cycle
- ifm_win  in  K*K*DW  element i at bits [i*DW +: DW], i=0 is row1/col1, row-major
- weight_win  in  K*K*WW  same packing, two's complement
- out_valid  out  1  ofm holds a result
- out_ready  in  1  downstream accepts ofm
- ofm  out  OW  signed result
- ch_idx  out  clog2(CIN) or 1 if CIN=1  index of the next channel beat to be accumulated

## Operation
- Transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage M (registered): each product is p_i = $signed({1'b0, ifm_i}) * weight_i, which is DW+WW+1 bits.
- Stage T: a binary adder tree with TL = clog2(K*K) registered levels. An odd element at a level is registered through unchanged. Each level grows the width by 1 bit, sign-extending. There is no truncation inside the tree.
- Stage A: a channel counter counts transfers that exit the tree, 0..CIN-1.
  - Count ≠ CIN-1: acc ← (count==0 ? 0 : acc) + sum, and the counter increments.
  - Count = CIN-1: ofm ← sat_OW(acc_or_0 + sum), out_valid ← 1, counter ← 0, acc ← 0.
- sat_OW clamps to [-2^(OW-1), 2^(OW-1)-1].
- ch_idx is the counter value.
- Stall: stall = out_valid && !out_ready, and in_ready = !stall. While stall is high, every pipeline register, valid bit, counter and acc holds its value. There are no bubbles and no loss.
- When out_valid && out_ready and a new result arrives in the same cycle, ofm loads the new value and out_valid stays 1. If nothing arrives, out_valid drops to 0.
- Reset (asynchronous): all stage valid bits, counter, acc, ofm and out_valid clear to 0.
  - in_ready reads 1 one cycle after rst_n deasserts.
  - Reset mid-accumulation discards partial sums. The next accepted window is channel 0.

## Timing
- Latency LAT = 1 + TL + 1 cycles, from the transfer of the CIN-th window to out_valid=1 without stalls. For K=3 this is 6 cycles; for K=5, TL=5, it is 7 cycles.
- Throughput is one window per cycle while out_ready is high. There is one output per CIN windows.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_valid.
- ofm and out_valid are registered outputs.
- in_valid deasserted mid-channel-group inserts bubbles. Partial acc is held until the remaining beats arrive.
- For CIN=1, acc is unused and every transfer produces an output.

## Configuration
- CONV_RELU_EN defined: the final stage applies ReLU after saturation. A negative result becomes 0; a non-negative result passes unchanged. There is no latency change.
- CONV_RELU_EN undefined: the signed saturated result is output as is.
- acc is never rectified; only the final value is.

## Test plan
- K=3, CIN=1, all ifm=1, all weights=1, single transfer -> out_valid at cycle +6, ofm=9, then out_valid=0 with out_ready=1.
- K=3, CIN=1, ifm=255, weights=-128 -> raw sum -293760.
  - Without the macro: ofm=-131072.
  - With CONV_RELU_EN: ofm=0.
- K=3, CIN=4, ifm=2, weights=3, four back-to-back transfers -> exactly one output, ofm=216, ch_idx sequence 0,1,2,3,0.
- Streaming 20 random windows with CIN=1, out_ready held low for 5 cycles -> in_ready=0 during the stall, no dropped or duplicated results, order matches the reference model.
- CIN=4: two transfers, then rst_n pulsed low mid-cycle, then four transfers of ifm=1, weights=1 -> single ofm=36, no residue from the first two.
- Packing check, K=3: only element 0 nonzero (ifm=7, weight=-2) -> ofm=-14. Only element 8 nonzero (ifm=200, weight=127) -> ofm=25400.

Source files
------------

// File: rtl/conv_kxk_mac.sv
// conv_kxk_mac: pipelined KxK convolution multiply-accumulate.
// The window products are reduced by a registered binary adder tree.
// Results are accumulated over CIN channel windows, then saturated to OW bits.
// Optional feature macro: CONV_RELU_EN applies ReLU to the saturated output.
// Pipeline: M (products) -> TL tree levels -> A (accumulate / output).
// A single stall (out_valid && !out_ready) freezes every stage together.
module conv_kxk_mac #(
  parameter int K    = 3,
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int CIN  = 1,
  parameter int ACCW = 32,
  parameter int OW   = 18
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [K*K*DW-1:0]                         ifm_win,
  input  logic [K*K*WW-1:0]                         weight_win,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [OW-1:0]                             ofm,
  output logic [((CIN > 1) ? $clog2(CIN) : 1)-1:0]  ch_idx
);

  localparam int NE = K * K;
  localparam int TL = $clog2(NE);
  localparam int PW = DW + WW + 1;
  localparam int SW = PW + TL;
  localparam int CW = (CIN > 1) ? $clog2(CIN) : 1;

  localparam logic signed [ACCW-1:0] OMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] OMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Number of nodes at tree level l (level 0 holds the products).
  function automatic int lvl_n(input int l);
    return (NE + (1 << l) - 1) >> l;
  endfunction

  // Clamp an accumulator value into the signed OW-bit range.
  function automatic logic signed [OW-1:0] sat_ow(input logic signed [ACCW-1:0] v);
    if (v > OMAX)      return OMAX[OW-1:0];
    else if (v < OMIN) return OMIN[OW-1:0];
    else               return v[OW-1:0];
  endfunction

`ifdef CONV_RELU_EN
  // Rectify the final saturated value.
  function automatic logic signed [OW-1:0] relu_ow(input logic signed [OW-1:0] v);
    return v[OW-1] ? '0 : v;
  endfunction
`endif

  logic stall;
  logic en;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  genvar l, j;
  for (l = 0; l <= TL; l++) begin : lvl
    localparam int N = lvl_n(l);
    localparam int W = PW + l;
    logic vld;

    if (l == 0) begin : g_in
      // ---- stage M: one registered product per window element ----
      for (j = 0; j < N; j++) begin : g_node
        logic signed [W-1:0] r;
        // Signed product of the zero-extended ifm element and its weight.
        always_ff @(posedge clk) begin
          if (en)
            r <= PW'($signed({1'b0, ifm_win[j*DW +: DW]})) * PW'($signed(weight_win[j*WW +: WW]));
        end
      end
      // Stage M valid bit follows the input handshake.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  vld <= 1'b0;
        else if (en) vld <= in_valid;
      end
    end else begin : g_in
      // ---- stage T level l: pairwise sums, odd tail passed through ----
      localparam int NP = lvl_n(l - 1);
      for (j = 0; j < N; j++) begin : g_node
        logic signed [W-1:0] r;
        if (2*j + 1 < NP) begin : g_pair
          // Sign-extending add of two nodes from the level below.
          always_ff @(posedge clk) begin
            if (en)
              r <= W'(lvl[l-1].g_in.g_node[2*j].r) + W'(lvl[l-1].g_in.g_node[2*j+1].r);
          end
        end else begin : g_pass
          // Unpaired node is registered unchanged, only widened.
          always_ff @(posedge clk) begin
            if (en) r <= W'(lvl[l-1].g_in.g_node[2*j].r);
          end
        end
      end
      // Valid bit shifts one tree level per unstalled cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  vld <= 1'b0;
        else if (en) vld <= lvl[l-1].vld;
      end
    end
  end

  // ---- stage A: channel accumulation, saturation, output register ----
  logic signed [SW-1:0]   sum_t;
  logic                   vld_t;
  logic [CW-1:0]          cnt;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] base;
  logic signed [ACCW-1:0] total;
  logic signed [OW-1:0]   fin;
  logic                   last;

  assign sum_t  = lvl[TL].g_in.g_node[0].r;
  assign vld_t  = lvl[TL].vld;
  assign ch_idx = cnt;

  // Combine tree output with the running channel sum and form the final value.
  always_comb begin
    last  = (cnt == CW'(CIN - 1));
    base  = (cnt == '0) ? '0 : acc;
    total = base + ACCW'(sum_t);
`ifdef CONV_RELU_EN
    fin   = relu_ow(sat_ow(total));
`else
    fin   = sat_ow(total);
`endif
  end

  // Channel counter, partial sum and output register; all frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      ofm       <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= vld_t && last;
      if (vld_t) begin
        if (last) begin
          ofm <= fin;
          cnt <= '0;
          acc <= '0;
        end else begin
          acc <= total;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_kxk_mac.sv
// Directed bench for conv_kxk_mac: one CIN=1 and one CIN=4 instance (K=3).
module tb_conv_kxk_mac;

  localparam int NE = 9;

`ifdef CONV_RELU_EN
  localparam int EXP_NEGSAT = 0;
  localparam int EXP_PACK0  = 0;
`else
  localparam int EXP_NEGSAT = -131072;
  localparam int EXP_PACK0  = -14;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [71:0] ifm1, wt1;
  logic [17:0] ofm1;
  logic [0:0]  ch1;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [71:0] ifm4, wt4;
  logic [17:0] ofm4;
  logic [1:0]  ch4;

  conv_kxk_mac #(.K(3), .DW(8), .WW(8), .CIN(1), .ACCW(32), .OW(18)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .ifm_win(ifm1), .weight_win(wt1), .out_valid(out_valid1),
    .out_ready(out_ready1), .ofm(ofm1), .ch_idx(ch1));

  conv_kxk_mac #(.K(3), .DW(8), .WW(8), .CIN(4), .ACCW(32), .OW(18)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .ifm_win(ifm4), .weight_win(wt4), .out_valid(out_valid4),
    .out_ready(out_ready4), .ofm(ofm4), .ch_idx(ch4));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] rep8(input logic [7:0] v);
    logic [71:0] r;
    for (int i = 0; i < NE; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic int model(input logic [71:0] a, input logic [71:0] b);
    int s;
    logic [7:0] x;
    logic signed [7:0] y;
    s = 0;
    for (int i = 0; i < NE; i++) begin
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      s += int'(x) * int'(y);
    end
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single CIN=1 transfer; result expected on the 6th edge counting the transfer edge.
  task automatic run1(input string tag, input logic [71:0] a, input logic [71:0] b, input int exp);
    ifm1 = a; wt1 = b; in_valid1 = 1'b1; out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    repeat (4) tick();
    chk({tag, "_early"}, int'(out_valid1), 0);
    tick();
    chk({tag, "_vld"}, int'(out_valid1), 1);
    chk(tag, $signed(ofm1), exp);
    tick();
    chk({tag, "_drop"}, int'(out_valid1), 0);
  endtask

  logic [71:0] sa [20];
  logic [71:0] sb [20];
  int          sexp [20];
  int          sent, rcv;

  initial begin
    #400000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid1 = 1'b0; out_ready1 = 1'b1; ifm1 = '0; wt1 = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; ifm4 = '0; wt4 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovld", int'(out_valid1), 0);
    chk("rst_ofm", $signed(ofm1), 0);
    chk("rst_ch1", int'(ch1), 0);
    chk("rst_ch4", int'(ch4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", int'(in_ready1), 1);

    // CIN=1 directed vectors
    run1("ones",   rep8(8'd1),   rep8(8'd1),   9);
    run1("negsat", rep8(8'd255), rep8(8'h80),  EXP_NEGSAT);
    run1("possat", rep8(8'd255), rep8(8'd127), 131071);
    run1("pack0",  72'd7,        72'hFE,       EXP_PACK0);
    run1("pack8",  {8'd200, 64'd0}, {8'd127, 64'd0}, 25400);

    // CIN=4: four back-to-back transfers of ifm=2, weight=3
    ifm4 = rep8(8'd2); wt4 = rep8(8'd3); in_valid4 = 1'b1;
    repeat (4) tick();
    in_valid4 = 1'b0;
    tick();
    chk("c4_ch0", int'(ch4), 0);
    tick();
    chk("c4_ch1", int'(ch4), 1);
    tick();
    chk("c4_ch2", int'(ch4), 2);
    tick();
    chk("c4_ch3", int'(ch4), 3);
    chk("c4_early", int'(out_valid4), 0);
    tick();
    chk("c4_wrap", int'(ch4), 0);
    chk("c4_vld", int'(out_valid4), 1);
    chk("c4_ofm", $signed(ofm4), 216);
    tick();
    chk("c4_single", int'(out_valid4), 0);
    repeat (4) tick();
    chk("c4_quiet", int'(out_valid4), 0);

    // CIN=4: reset mid-accumulation discards the partial sum
    ifm4 = rep8(8'd5); wt4 = rep8(8'd5); in_valid4 = 1'b1;
    repeat (2) tick();
    in_valid4 = 1'b0;
    repeat (5) tick();
    chk("mid_ch", int'(ch4), 2);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    chk("mid_clr", int'(ch4), 0);
    tick();
    ifm4 = rep8(8'd1); wt4 = rep8(8'd1); in_valid4 = 1'b1;
    repeat (4) tick();
    in_valid4 = 1'b0;
    repeat (4) tick();
    chk("mid_early", int'(out_valid4), 0);
    tick();
    chk("mid_vld", int'(out_valid4), 1);
    chk("mid_ofm", $signed(ofm4), 36);
    tick();
    chk("mid_single", int'(out_valid4), 0);

    // CIN=1 streaming with a 5-cycle downstream stall
    for (int i = 0; i < 20; i++) begin
      for (int e = 0; e < NE; e++) begin
        sa[i][e*8 +: 8] = 8'($urandom_range(0, 255));
        sb[i][e*8 +: 8] = 8'($urandom_range(0, 255));
      end
      sexp[i] = model(sa[i], sb[i]);
    end
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      in_valid1 = (sent < 20);
      if (sent < 20) begin
        ifm1 = sa[sent];
        wt1  = sb[sent];
      end
      out_ready1 = !(cyc >= 10 && cyc < 15);
      #1;
      if (!out_ready1) begin
        chk("stall_ovld", int'(out_valid1), 1);
        chk("stall_rdy", int'(in_ready1), 0);
      end
      if (out_valid1 && out_ready1) begin
        if (rcv < 20) chk("stream", $signed(ofm1), sexp[rcv]);
        else          chk("stream_extra", rcv, 19);
        rcv++;
      end
      if (in_valid1 && in_ready1) sent++;
      if (sent >= 20 && rcv >= 20 && cyc > 40) break;
      tick();
    end
    in_valid1 = 1'b0;
    chk("stream_count", rcv, 20);
    repeat (8) tick();
    chk("stream_quiet", int'(out_valid1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
